// File: rtl/chameleon_usart_pkg.sv
// Shared definitions for the Chameleon microcontroller-link USART receiver:
// deframer state encoding, character width and synchroniser depth.
package chameleon_usart_pkg;

  // Data bits per character (start + 8 data + stop framing).
  localparam int USART_DATA_BITS = 8;

  // Flip-flops in each input synchroniser chain.
  localparam int USART_SYNC_STAGES = 2;

  // Deframer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_e;

endpackage

// File: rtl/chameleon_usart_rx_fifo.sv
// Receive buffer between the deframer and the sysclk-side consumer.
// Build option CHAMELEON_USART_RX_FIFO_EN selects a FIFO_DEPTH-entry circular
// FIFO; without it the buffer is a single holding register.
// Show-ahead: rd_data always presents the oldest entry while not empty.
// A pop on a full buffer frees the slot in the same cycle, so a coincident
// push is accepted.
module chameleon_usart_rx_fifo
  import chameleon_usart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       sysclk,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [USART_DATA_BITS-1:0] wr_data,
  output logic [USART_DATA_BITS-1:0] rd_data,
  output logic                       full,
  output logic                       empty
);

`ifdef CHAMELEON_USART_RX_FIFO_EN

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [USART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; contents reset to zero so rd_data reads 0.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`else

  // FIFO_DEPTH has no role with a single holding register.
  localparam int fifo_depth_unused = FIFO_DEPTH;

  logic [USART_DATA_BITS-1:0] hold_q;
  logic                       hold_valid;
  logic                       do_push;
  logic                       do_pop;

  assign empty   = !hold_valid;
  assign full    = hold_valid;
  assign rd_data = hold_q;
  assign do_pop  = pop && hold_valid;
  assign do_push = push && (!hold_valid || do_pop);

  // Single-entry holding register; a push wins over a coincident pop.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else if (do_push) begin
      hold_q     <= wr_data;
      hold_valid <= 1'b1;
    end else if (do_pop) begin
      hold_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/chameleon_usart_rx.sv
// Synchronous serial receiver for the Chameleon microcontroller link.
// Samples usart_tx on rising edges of the externally supplied usart_clk,
// deframes start/8-data/stop characters (LSB first) and hands bytes to the
// sysclk domain through a buffer.
// Build option CHAMELEON_USART_RX_FIFO_EN: multi-entry FIFO instead of a
// single holding register (see chameleon_usart_rx_fifo).
//
// Output handshake: rx_valid high means rx_data holds the oldest received
// byte; a byte transfers on every sysclk cycle where rx_valid & rx_ready,
// and rx_data only moves on to the next byte after such a transfer.
//
// frame_err / overrun / timeout are single-cycle pulses raised the cycle after
// the usart_clk edge (or timeout count) that caused them. The deframer state
// is held in the enum-typed register 'state'.
module chameleon_usart_rx #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic       sysclk,
  input  logic       n_reset,
  input  logic       usart_clk,
  input  logic       usart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       timeout,
  output logic       busy
);

  import chameleon_usart_pkg::*;

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam int              BW       = $clog2(USART_DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(USART_DATA_BITS - 1);

  logic [USART_SYNC_STAGES-1:0] clk_sync;
  logic [USART_SYNC_STAGES-1:0] dat_sync;
  logic                         clk_prev;
  logic                         clk_rise;
  logic                         rx_bit;

  rx_state_e                  state;
  logic [BW-1:0]              bitcnt;
  logic [USART_DATA_BITS-1:0] shreg;
  logic [TW-1:0]              to_cnt;
  logic                       to_hit;

  logic push_req;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  // Two-flop synchronisers (idle-high reset) plus the clock-edge history flop.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[USART_SYNC_STAGES-2:0], usart_clk};
      dat_sync <= {dat_sync[USART_SYNC_STAGES-2:0], usart_tx};
      clk_prev <= clk_sync[USART_SYNC_STAGES-1];
    end
  end

  assign clk_rise = clk_sync[USART_SYNC_STAGES-1] & ~clk_prev;
  assign rx_bit   = dat_sync[USART_SYNC_STAGES-1];

  // An edge always wins over an expiring count; the count only matters mid-frame.
  assign to_hit = (state != IDLE) && !clk_rise && (to_cnt == TO_LIMIT);

  // Inter-edge watchdog: cleared on each edge and while idle, saturates at the limit.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      to_cnt <= '0;
    end else if ((state == IDLE) || clk_rise) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Deframer FSM with registered frame_err / timeout pulses.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (clk_rise && !rx_bit) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: begin
          if (clk_rise) begin
            shreg  <= {rx_bit, shreg[USART_DATA_BITS-1:1]};
            bitcnt <= bitcnt + BW'(1);
            if (bitcnt == LAST_BIT) begin
              state <= STOP;
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        STOP: begin
          if (clk_rise) begin
            frame_err <= !rx_bit;
            state     <= IDLE;
          end else if (to_hit) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A good stop bit hands the assembled byte to the buffer on the edge cycle.
  assign push_req = (state == STOP) && clk_rise && rx_bit;
  assign pop      = rx_valid && rx_ready;
  assign rx_valid = !fifo_empty;
  assign busy     = (state != IDLE);

  // Overrun pulse: a completed byte arrives while the buffer is full and
  // nothing is being taken out in the same cycle.
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && fifo_full && !pop;
    end
  end

  chameleon_usart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk  (sysclk),
    .n_reset (n_reset),
    .push    (push_req),
    .pop     (pop),
    .wr_data (shreg),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Bench for chameleon_usart_rx: frame-level reference model (expected byte
// queue plus expected flag counts) and a per-cycle scoreboard on the outputs.
`timescale 1ns/1ps
module tb_chameleon_usart_rx;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 4095;
`ifdef CHAMELEON_USART_RX_FIFO_EN
  localparam int CAP    = FIFO_DEPTH;
  localparam int OV_LIT = 1;
`else
  localparam int CAP    = 1;
  localparam int OV_LIT = 4;
`endif

  logic       sysclk;
  logic       n_reset;
  logic       usart_clk;
  logic       usart_tx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       timeout;
  logic       busy;

  logic rand_ready_en;
  logic rand_ready;
  logic ready_cmd;
  assign rx_ready = rand_ready_en ? rand_ready : ready_cmd;

  int cyc;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_cmp;
  int n_fail;
  int fe_cnt, ov_cnt, to_cnt;
  int exp_fe, exp_ov, exp_to;
  logic fe_d, ov_d, to_d;

  chameleon_usart_rx #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .sysclk    (sysclk),
    .n_reset   (n_reset),
    .usart_clk (usart_clk),
    .usart_tx  (usart_tx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .timeout   (timeout),
    .busy      (busy)
  );

  // Clock and cycle counter
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // Random consumer readiness, used only when rand_ready_en is set
  initial rand_ready = 1'b1;
  always @(posedge sysclk) begin
    #1;
    rand_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Scoreboard: compare delivered bytes with the model queue, count flag pulses
  task automatic scoreboard();
    forever begin
      @(negedge sysclk);
      if (n_reset) begin
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            check("valid_when_empty", rx_valid, 1'b0);
          end else begin
            check("rx_data", rx_data, exp_q[0]);
            if (rx_ready) begin
              got_q.push_back(rx_data);
              void'(exp_q.pop_front());
            end
          end
        end
        if (frame_err) begin fe_cnt++; check("frame_err_width", fe_d, 1'b0); end
        if (overrun)   begin ov_cnt++; check("overrun_width",   ov_d, 1'b0); end
        if (timeout)   begin to_cnt++; check("timeout_width",   to_d, 1'b0); end
        fe_d = frame_err;
        ov_d = overrun;
        to_d = timeout;
      end else begin
        fe_d = 1'b0;
        ov_d = 1'b0;
        to_d = 1'b0;
      end
    end
  endtask

  // Driver: one serial bit, data set while usart_clk is low
  task automatic send_bit(input logic v);
    usart_clk = 1'b0;
    usart_tx  = v;
    tick($urandom_range(3, 6));
    usart_clk = 1'b1;
    tick($urandom_range(3, 6));
  endtask

  // Driver: full character; model decides the outcome at the stop-bit edge.
  // pop_at_stop pulses rx_ready in the cycle the DUT performs the push.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic pop_at_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    usart_clk = 1'b0;
    usart_tx  = stop_ok;
    tick($urandom_range(3, 6));
    usart_clk = 1'b1;
    if (!stop_ok) exp_fe++;
    else if ((exp_q.size() < CAP) || pop_at_stop) exp_q.push_back(b);
    else exp_ov++;
    if (pop_at_stop) begin
      tick(2);
      ready_cmd = 1'b1;
      tick(1);
      ready_cmd = 1'b0;
      tick($urandom_range(0, 3));
    end else begin
      tick($urandom_range(3, 6));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 400)) begin
      tick(1);
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic check_flags(input string tag);
    tick(3);
    check({tag, "_frame_err_count"}, fe_cnt, exp_fe);
    check({tag, "_overrun_count"},   ov_cnt, exp_ov);
    check({tag, "_timeout_count"},   to_cnt, exp_to);
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge sysclk);
    check({tag, "_rx_valid"},  rx_valid,  1'b0);
    check({tag, "_rx_data"},   rx_data,   8'h00);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_overrun"},   overrun,   1'b0);
    check({tag, "_timeout"},   timeout,   1'b0);
    check({tag, "_busy"},      busy,      1'b0);
  endtask

  initial begin
    int rise_cyc;
    int n;
    int ov_before;
    logic [7:0] lit3 [4];
    logic [7:0] b;
    lit3 = '{8'h01, 8'h02, 8'h03, 8'h04};
    n_cmp = 0; n_fail = 0;
    fe_cnt = 0; ov_cnt = 0; to_cnt = 0;
    exp_fe = 0; exp_ov = 0; exp_to = 0;
    fe_d = 1'b0; ov_d = 1'b0; to_d = 1'b0;
    n_reset = 1'b0;
    usart_clk = 1'b0;
    usart_tx = 1'b1;
    ready_cmd = 1'b0;
    rand_ready_en = 1'b0;
    fork
      scoreboard();
    join_none

    // Reset state
    tick(3);
    check_idle_outputs("reset");
    tick(1);
    n_reset = 1'b1;
    tick(3);
    check_idle_outputs("after_reset");

    // Single good frame, consumer always ready
    ready_cmd = 1'b1;
    got_q.delete();
    send_frame(8'hA5, 1'b1, 1'b0);
    check_flags("a5");
    check("a5_count", got_q.size(), 1);
    if (got_q.size() > 0) check("a5_value", got_q[0], 8'hA5);
    check("a5_no_flags", fe_cnt + ov_cnt + to_cnt, 0);

    // Bad stop bit
    got_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    check_flags("stop_low");
    check("stop_low_fe_literal", fe_cnt, 1);
    check("stop_low_no_byte", got_q.size(), 0);

    // Overrun with consumer stalled
    ready_cmd = 1'b0;
    got_q.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check_flags("overrun");
    check("overrun_literal", ov_cnt, OV_LIT);
    ready_cmd = 1'b1;
    drain();
    check("overrun_drain_count", got_q.size(), CAP);
    for (int i = 0; i < CAP && i < got_q.size(); i++) check("overrun_drain_order", got_q[i], lit3[i]);

    // Timeout: start + 3 data bits, then usart_clk stops
    got_q.delete();
    send_bit(1'b0);
    send_bit(1'b1);
    check("busy_mid_frame", busy, 1'b1);
    send_bit(1'b0);
    usart_clk = 1'b0;
    usart_tx  = 1'b1;
    tick(4);
    usart_clk = 1'b1;
    rise_cyc = cyc;
    exp_to++;
    n = 0;
    while (n < 6000) begin
      @(negedge sysclk);
      n++;
      if (timeout) break;
    end
    check("timeout_seen", timeout, 1'b1);
    check("timeout_latency", cyc - rise_cyc, 3 + TIMEOUT_CYCLES + 1);
    check("timeout_busy_low", busy, 1'b0);
    tick(2);
    send_frame(8'h55, 1'b1, 1'b0);
    check_flags("timeout");
    check("after_timeout_count", got_q.size(), 1);
    if (got_q.size() > 0) check("after_timeout_value", got_q[0], 8'h55);

    // Reset in the middle of a frame
    got_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n_reset = 1'b0;
    tick(1);
    check_idle_outputs("mid_reset");
    usart_clk = 1'b0;
    usart_tx  = 1'b1;
    exp_q.delete();
    tick(3);
    n_reset = 1'b1;
    tick(2);
    send_frame(8'h81, 1'b1, 1'b0);
    check_flags("reset_frame");
    check("reset_frame_count", got_q.size(), 1);
    if (got_q.size() > 0) check("reset_frame_value", got_q[0], 8'h81);

    // Full buffer, push coinciding with a pop
    ready_cmd = 1'b0;
    got_q.delete();
    for (int i = 0; i < CAP; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    ov_before = ov_cnt;
    send_frame(8'h77, 1'b1, 1'b1);
    check_flags("coincide");
    check("coincide_no_overrun", ov_cnt, ov_before);
    ready_cmd = 1'b1;
    drain();
    check("coincide_count", got_q.size(), CAP + 1);
    if (got_q.size() == CAP + 1) begin
      check("coincide_first", got_q[0], 8'h10);
      check("coincide_last", got_q[CAP], 8'h77);
    end

    // Randomized frames, random stop bits, random idle clocks, random readiness
    rand_ready_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        usart_clk = 1'b0;
        usart_tx  = 1'b1;
        tick($urandom_range(3, 6));
        usart_clk = 1'b1;
        tick($urandom_range(3, 6));
      end
      b = 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 7) != 0), 1'b0);
      tick($urandom_range(0, 8));
    end
    drain();
    check_flags("random");
    rand_ready_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/chameleon_usart_rx.md
# chameleon_usart_rx

Synchronous serial receiver for the Chameleon's microcontroller link. It samples the `usart_tx` line, which the on-board microcontroller drives, on rising edges of the externally supplied `usart_clk`. It deframes start/8-data/stop characters and delivers bytes to the sysclk domain through a valid/ready handshake. It is the receive counterpart of the reconfigure transmitter, which drives `usart_rx`/`usart_rts`, and feeds host-side logic such as cfide command and menu handling.

## Interface
- `FIFO_DEPTH`, default 4: receive buffer entries, power of two, minimum 2; used only with the FIFO compiled in.
- `TIMEOUT_CYCLES`, default 4095: maximum sysclk cycles between `usart_clk` rising edges inside a frame before the frame is aborted; must be at least 16.

Ports:
- `sysclk`, in, 1: system clock; all logic is on its rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `usart_clk`, in, 1: serial bit clock from the microcontroller, asynchronous to sysclk.
- `usart_tx`, in, 1: serial data from the microcontroller; idles high.
- `rx_data`, out, 8: received byte, valid while `rx_valid` is high.
- `rx_valid`, out, 1: a byte is available.
- `rx_ready`, in, 1: consumer accepts the byte. A transfer occurs when `rx_valid & rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped because the buffer is full.
- `timeout`, out, 1: one-cycle pulse when an in-frame abort occurs.
- `busy`, out, 1: receiver is mid-frame (state is not IDLE).

## Operation
- Input conditioning: `usart_clk` and `usart_tx` each pass through a 2-FF synchroniser, reset value 1. A third register on the clock path detects a rising edge (`edge` = sync & ~prev).
- State machine:
  - IDLE: on `edge` with synchronised data 0 (start bit), go to DATA with `bitcnt`=0. On `edge` with data 1, stay in IDLE.
  - DATA: on each `edge`, shift the data bit into `shreg[7]` and shift right (LSB first), then increment `bitcnt`. After the 8th bit (`bitcnt`=7 on that edge), go to STOP.
  - STOP: on `edge`, if data is 1, push `shreg` into the buffer. If data is 0, pulse `frame_err` and discard the byte. Either way, return to IDLE.
- Timeout: a counter is cleared on every `edge` and when in IDLE, and increments otherwise. When it reaches `TIMEOUT_CYCLES` in DATA or STOP, pulse `timeout`, discard the partial byte, and go to IDLE. The counter saturates and does not wrap.
- Buffer full at push time: pulse `overrun`, drop the new byte, and leave existing contents unchanged.
- Push and pop in the same cycle on a full buffer: the pop frees the slot, so the push succeeds with no overrun.
- Reset values: state IDLE, `bitcnt` 0, `shreg` 0, buffer empty, `rx_data` 0, and all outputs 0.
- Reset asserted mid-frame abandons the frame; no byte is delivered and no flags are raised.

## Timing
- Edge detection occurs 3 sysclk cycles after `usart_clk` rises.
- `usart_clk` high and low phases must each be at least 3 sysclk cycles. Data must be stable for 3 cycles around the rising edge.
- Byte latency: `rx_valid` rises 1 cycle after the STOP-state `edge` cycle.
- Output order: show-ahead. `rx_data` presents the oldest entry whenever `rx_valid` is high and changes only after a transfer.
- Throughput: one transfer per cycle. An empty buffer with `rx_ready` held high delivers each byte for exactly 1 cycle.
- `frame_err`, `overrun` and `timeout` assert in the cycle after the causing `edge` or count and last 1 cycle.

## Configuration
- `CHAMELEON_USART_RX_FIFO_EN` defined: buffer is a `FIFO_DEPTH`-entry circular FIFO with read/write pointers one bit wider than the index, for full/empty discrimination.
- Not defined: buffer is a single holding register. It is full while `rx_valid` is high. `FIFO_DEPTH` is ignored.
- All other behaviour is identical with or without the macro.

## Structure
- Package `chameleon_usart_pkg` holds:
  - the state enum (IDLE, DATA, STOP),
  - constant `USART_DATA_BITS`=8,
  - the synchroniser depth constant.
- Sub-module `chameleon_usart_rx_fifo` provides the buffer, with ports push/pop/full/empty/data in and out. Both macro variants are implemented inside it.

## Test plan
- Send 0xA5 framed correctly with `rx_ready`=1 → `rx_data`=0xA5 with a 1-cycle `rx_valid` pulse; no flags.
- Send 0x3C with the stop bit low → `frame_err` pulses once; `rx_valid` stays 0.
- Send 0x01,0x02,0x03,0x04,0x05 with `rx_ready`=0 and the FIFO enabled at depth 4 → `overrun` pulses on 0x05; draining yields 0x01–0x04 in order. Without the macro, `overrun` pulses on 0x02 and draining yields 0x01.
- Send start bit plus 3 data bits, then hold `usart_clk` → `timeout` pulses after 4095 cycles; `busy` falls; a following 0x55 frame is received correctly.
- Assert `n_reset` low after 4 data bits of 0xFF, release, then send 0x81 → only 0x81 is delivered; all outputs are 0 during reset.
- Buffer full, then a STOP-state push coinciding with a pop → no `overrun`; the byte count is preserved and ordering is correct.
